// File: rtl/com_emit_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | com_emit_seq : walks com_rom for one code template and streams ARM words.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module com_emit_seq #(
  parameter int ROM_AW = 7,
  parameter int LEN_W  = 4,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ROM_AW-1:0] req_base,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              req_patch_en,
  input  logic [LEN_W-1:0]  req_patch_idx,
  input  logic [23:0]       req_imm,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic              out_last,
  output logic [PC_W-1:0]   out_pc,
  output logic              done,
  output logic              err
);

  localparam logic [31:0] C_UNPOP = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_alive;
  logic [ROM_AW-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic              r_patch_en;
  logic [LEN_W-1:0]  r_patch_idx;
  logic [23:0]       r_imm;
  logic [LEN_W-1:0]  r_idx;

  logic              w_accept;
  logic              w_load;
  logic              w_hs;
  logic              w_unpop;
  logic              w_final;
  logic              w_patch;
  logic [31:0]       w_word;

  // r_alive keeps req_ready low while reset is held and until the first clock after it.
  assign req_ready = r_alive && (r_state == S_IDLE) && !out_valid;
  assign w_accept  = req_valid && req_ready;
  assign w_hs      = out_valid && out_ready;
  assign w_load    = (r_state == S_EMIT) && (!out_valid || out_ready);
  assign rom_addr  = r_base + ROM_AW'(r_idx);
  assign w_unpop   = (rom_data == C_UNPOP);
  assign w_final   = (r_idx == (r_len - LEN_W'(1)));
  assign w_patch   = r_patch_en && (r_idx == r_patch_idx);
  assign w_word    = w_patch ? {rom_data[31:24], r_imm} : rom_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_alive     <= 1'b0;
      r_base      <= '0;
      r_len       <= '0;
      r_patch_en  <= 1'b0;
      r_patch_idx <= '0;
      r_imm       <= '0;
      r_idx       <= '0;
      out_valid   <= 1'b0;
      out_word    <= '0;
      out_last    <= 1'b0;
      out_pc      <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      done    <= w_hs && out_last;
      err     <= 1'b0;

      if (w_hs) begin
        out_valid <= 1'b0;
        out_pc    <= out_pc + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_base      <= req_base;
            r_len       <= req_len;
            r_patch_en  <= req_patch_en;
            r_patch_idx <= req_patch_idx;
            r_imm       <= req_imm;
            r_idx       <= '0;
            out_valid   <= 1'b0;
            if (req_len == '0) begin
              done <= 1'b1;
            end else begin
              r_state <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (w_load) begin
            // An unpopulated fetch drops the rest of the template; a held word still drains.
            if (w_unpop) begin
              err     <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              out_valid <= 1'b1;
              out_word  <= w_word;
              out_last  <= w_final;
              r_idx     <= r_idx + 1'b1;
              if (w_final) begin
                r_state <= S_IDLE;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_com_emit_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_com_emit_seq : scoreboard bench for com_emit_seq with a ROM image.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_com_emit_seq;

  localparam int ROM_AW = 7;
  localparam int LEN_W  = 4;
  localparam int PC_W   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ROM_AW-1:0] req_base;
  logic [LEN_W-1:0]  req_len;
  logic              req_patch_en;
  logic [LEN_W-1:0]  req_patch_idx;
  logic [23:0]       req_imm;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic              out_last;
  logic [PC_W-1:0]   out_pc;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  com_emit_seq #(.ROM_AW(ROM_AW), .LEN_W(LEN_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_len(req_len),
    .req_patch_en(req_patch_en), .req_patch_idx(req_patch_idx), .req_imm(req_imm),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_last(out_last), .out_pc(out_pc), .done(done), .err(err)
  );

  logic [31:0] rom [0:127];
  assign rom_data = rom[rom_addr];

  typedef struct packed {
    logic [31:0]     word;
    logic            last;
    logic [PC_W-1:0] pc;
  } exp_t;

  exp_t            exp_q[$];
  byte             evt_q[$];
  int              n_cmp = 0;
  int              n_bad = 0;
  int              hs_count = 0;
  int              ready_mode = 0;
  logic [PC_W-1:0] pc_model = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Reference: walk the template, stop at the first FFFFFFFF entry.
  function automatic void model(input logic [6:0] b, input logic [3:0] l, input logic pe,
                                input logic [3:0] pi, input logic [23:0] im);
    logic [6:0]  a;
    logic [31:0] w;
    exp_t        e;
    for (int i = 0; i < int'(l); i++) begin
      a = b + 7'(i);
      w = rom[a];
      if (w == 32'hFFFF_FFFF) begin
        evt_q.push_back("E");
        return;
      end
      if (pe && (i == int'(pi))) w[23:0] = im;
      e.word = w;
      e.last = (i == int'(l) - 1);
      e.pc   = pc_model;
      exp_q.push_back(e);
      pc_model = pc_model + 1'b1;
    end
    evt_q.push_back("D");
  endfunction

  // Monitor: handshakes, held-word stability and done/err pulses.
  logic [31:0] held_word;
  logic        held_last;
  bit          holding = 1'b0;
  initial begin
    exp_t e;
    byte  got;
    byte  want;
    forever begin
      @(negedge clk);
      if (rst) begin
        holding = 1'b0;
      end else begin
        if (holding) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_word", out_word, held_word);
          check("hold_last", 32'(out_last), 32'(held_last));
        end
        holding = out_valid && !out_ready;
        if (holding) begin
          held_word = out_word;
          held_last = out_last;
        end
        if (out_valid && out_ready) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_word: got %h, expected no word", out_word);
          end else begin
            e = exp_q.pop_front();
            check("word", out_word, e.word);
            check("last", 32'(out_last), 32'(e.last));
            check("pc", 32'(out_pc), 32'(e.pc));
          end
        end
        if (done || err) begin
          got = done ? "D" : "E";
          if (done && err) got = "B";
          if (evt_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_event: got %s, expected none", got);
          end else begin
            want = evt_q.pop_front();
            check("event", 32'(got), 32'(want));
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic issue(input logic [6:0] b, input logic [3:0] l, input logic pe,
                       input logic [3:0] pi, input logic [23:0] im);
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL req_ready_timeout: got 0, expected 1");
      return;
    end
    req_valid = 1'b1; req_base = b; req_len = l;
    req_patch_en = pe; req_patch_idx = pi; req_imm = im;
    model(b, l, pe, pi, im);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || evt_q.size() != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("drain_words", 32'(exp_q.size()), 32'd0);
    check("drain_events", 32'(evt_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    for (int a = 0; a < 128; a++) rom[a] = 32'hE280_0000 | (a << 8) | a;
    rom[7'h07] = 32'hE1A0_2000;
    rom[7'h2B] = 32'hE92D_4800;
    rom[7'h2C] = 32'hEB00_0000;
    rom[7'h2D] = 32'hE8BD_4800;
    rom[7'h41] = 32'hED90_0B00;
    rom[7'h42] = 32'hED80_0B00;
    rom[7'h43] = 32'hFFFF_FFFF;
    rom[7'h55] = 32'hFFFF_FFFF;
    rom[7'h60] = 32'hFFFF_FFFF;
    rom[7'h7F] = 32'hFFFF_FFFF;

    rst = 1'b1; req_valid = 1'b0; req_base = '0; req_len = '0;
    req_patch_en = 1'b0; req_patch_idx = '0; req_imm = '0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_out_pc", 32'(out_pc), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Basic with patch, including first-word latency.
    issue(7'h2B, 4'd3, 1'b1, 4'd1, 24'h000010);
    @(negedge clk);
    check("lat_t1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_t2_valid", 32'(out_valid), 32'd1);
    check("lat_t2_word", out_word, 32'hE92D_4800);
    wait_idle();
    check("basic_pc", 32'(out_pc), 32'd3);

    ready_mode = 1;
    issue(7'h2B, 4'd3, 1'b1, 4'd1, 24'h000010);
    wait_idle();
    check("bp_pc", 32'(out_pc), 32'd6);
    ready_mode = 0;

    // Zero length: done and req_ready in the cycle after acceptance.
    issue(7'h10, 4'd0, 1'b0, 4'd0, 24'h0);
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_ready", 32'(req_ready), 32'd1);
    check("zero_valid", 32'(out_valid), 32'd0);
    wait_idle();

    issue(7'h41, 4'd4, 1'b0, 4'd0, 24'h0);
    wait_idle();

    // Wrap: first fetch at 0x7F is a hole, err lands at T+2.
    issue(7'h7F, 4'd2, 1'b0, 4'd0, 24'h0);
    @(negedge clk);
    check("wrap_err_t1", 32'(err), 32'd0);
    @(negedge clk);
    check("wrap_err_t2", 32'(err), 32'd1);
    wait_idle();

    // Reset after the third handshake of a long template.
    target = hs_count + 3;
    issue(7'h01, 4'd10, 1'b0, 4'd0, 24'h0);
    for (int t = 0; t < 200 && hs_count < target; t++) @(posedge clk);
    if (hs_count < target) begin
      n_cmp++; n_bad++;
      $display("FAIL mid_reset_wait: got %0d handshakes, expected %0d", hs_count, target);
    end
    #2;
    rst = 1'b1;
    exp_q.delete();
    evt_q.delete();
    pc_model = '0;
    #1;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_pc", 32'(out_pc), 32'd0);
    check("mrst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(7'h07, 4'd1, 1'b0, 4'd0, 24'h0);
    wait_idle();

    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      issue(7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 24'($urandom));
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
